// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and step-result encoding for the Gray decode stage.
package gray_pkg;

    // Widest word the generic helper below handles; narrower words are zero-extended.
    localparam int GRAY_MAX_W = 32;

    // Step direction encoding as reported on out_dir.
    localparam logic STEP_UP = 1'b1;
    localparam logic STEP_DN = 1'b0;

    // Gray-to-binary decode. Leading zeros decode to zeros, so a zero-extended
    // narrower word yields the correct zero-extended binary value.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational N-bit Gray-to-binary decoder.
// Each binary bit is the XOR of its Gray bit and every Gray bit above it,
// which is the unrolled form of the MSB-first ripple.
module gray2bin_comb #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/gray_decode_stage.sv
// Registered, handshaked Gray-to-binary decode stage with +/-1 step check
// and a saturating step-error tally.
module gray_decode_stage
    import gray_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_gray,
    input  logic             clr_hist,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_bin,
    output logic             out_first,
    output logic             out_dir,
    output logic             out_step_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0] bin;
    logic [N-1:0] last;
    logic [N-1:0] last_inc;
    logic [N-1:0] last_dec;
    logic         hv;
    logic         accept;
    logic         xfer;
    logic         first_w;
    logic         up_w;
    logic         dn_w;
    logic         err_w;

    gray2bin_comb #(.N(N)) u_dec (
        .gray (in_gray),
        .bin  (bin)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // Step classification of the incoming word against the previous accepted one.
    // A same-cycle clr_hist makes this word a fresh start.
    always_comb begin
        last_inc = last + N'(1);
        last_dec = last - N'(1);
        first_w  = !hv || clr_hist;
        up_w     = !first_w && (bin == last_inc);
        dn_w     = !first_w && (bin == last_dec);
        err_w    = !first_w && !up_w && !dn_w;
    end

    // Output register, history and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_bin      <= '0;
            out_first    <= 1'b0;
            out_dir      <= 1'b0;
            out_step_err <= 1'b0;
            err_count    <= '0;
            last         <= '0;
            hv           <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_bin      <= bin;
            out_first    <= first_w;
            out_dir      <= up_w ? STEP_UP : STEP_DN;
            out_step_err <= err_w;
            last         <= bin;
            hv           <= 1'b1;
            if (err_w && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end else begin
            if (xfer) begin
                out_valid <= 1'b0;
            end
            if (clr_hist) begin
                hv <= 1'b0;
            end
        end
    end

endmodule
